// File: rtl/i2s_rx_fblk_dcfilt_if.sv
// RAM-side bus of the block DC filter: read port of the idle Rx bank and the
// write-back port for filtered samples. Parameter ADDR_W matches the filter.
interface i2s_rx_fblk_dcfilt_if #(
  parameter int ADDR_W = 10
);
  // Transfer semantics: there is no valid/ready pair on this bus. A read
  // address presented in one cycle returns data on L_f_RAM_RD_DATA_i in the
  // next cycle; a write takes place in every cycle with L_f_RAM_Wr_en_o high,
  // and the RAM must always accept it (it never stalls the filter).
  logic [15:0]       L_f_RAM_RD_DATA_i;
  logic [ADDR_W-1:0] L_f_RAM_RaDDR_o;
  logic [ADDR_W-1:0] L_f_RAM_WaDDR_o;
  logic              L_f_RAM_Wr_en_o;
  logic [15:0]       L_f_RAM_WR_DATA_o;

  modport master (
    input  L_f_RAM_RD_DATA_i,
    output L_f_RAM_RaDDR_o,
    output L_f_RAM_WaDDR_o,
    output L_f_RAM_Wr_en_o,
    output L_f_RAM_WR_DATA_o
  );

  modport slave (
    output L_f_RAM_RD_DATA_i,
    input  L_f_RAM_RaDDR_o,
    input  L_f_RAM_WaDDR_o,
    input  L_f_RAM_Wr_en_o,
    input  L_f_RAM_WR_DATA_o
  );
endinterface

// File: rtl/i2s_rx_fblk_dcfilt.sv
// Block-mode DC-removal filter over a filled Rx RAM bank (read, filter, write back).
// Optional peak-magnitude tracking is built when I2S_FBLK_PEAK_EN is defined.
module i2s_rx_fblk_dcfilt #(
  parameter int ADDR_W = 10
) (
  input  logic                        WBs_CLK_i,
  input  logic                        WBs_RST_i,
  input  logic                        f_start_i,
  input  logic                        enable_i,
  input  logic [3:0]                  shift_i,
  i2s_rx_fblk_dcfilt_if.master        ram,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o,
  output logic [15:0]                 peak_o,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_PROC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_nxt;
  logic                idx_last;
  logic                start_blk;

  logic signed [23:0]  dc;
  logic signed [23:0]  dc_nxt;
  logic        [15:0]  x;
  logic        [15:0]  y;
  logic signed [24:0]  diff;
  logic signed [24:0]  diff_sh;
  logic        [16:0]  y_wide;
  logic                bypass;

  assign x         = ram.L_f_RAM_RD_DATA_i;
  assign idx_last  = (idx == {ADDR_W{1'b1}});
  assign bypass    = (shift_i == 4'd0);
  assign start_blk = (state == S_IDLE) && f_start_i && enable_i;
  assign state_dbg = state;

  // dc is 16.8 fixed point; the sample is lifted to the same scale before the
  // difference, and the arithmetic shift sets the tracking time constant.
  always_comb begin
    diff    = {x[15], x, 8'h00} - {dc[23], dc};
    diff_sh = diff >>> shift_i;
    dc_nxt  = dc + diff_sh[23:0];
    y_wide  = {x[15], x} - {dc[23], dc[23:8]};
    if (bypass) begin
      y = x;
    end else if (y_wide[16] != y_wide[15]) begin
      y = y_wide[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      y = y_wide[15:0];
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      dc        <= '0;
      overrun_o <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if ((state == S_PROC) && !bypass) begin
        dc <= dc_nxt;
      end
      // A start request arriving in any busy state, DONE included, is dropped.
      if (f_start_i && (state != S_IDLE)) begin
        overrun_o <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start_blk) begin
          state_nxt = S_READ;
          idx_nxt   = '0;
        end
      end
      S_READ: begin
        state_nxt = S_PROC;
      end
      S_PROC: begin
        if (idx_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_READ;
          idx_nxt   = idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so the RAM never sees a stray write.
  always_comb begin
    ram.L_f_RAM_RaDDR_o   = '0;
    ram.L_f_RAM_WaDDR_o   = '0;
    ram.L_f_RAM_Wr_en_o   = 1'b0;
    ram.L_f_RAM_WR_DATA_o = 16'h0000;
    busy_o                = 1'b0;
    done_o                = 1'b0;
    if (!WBs_RST_i) begin
      case (state)
        S_READ: begin
          ram.L_f_RAM_RaDDR_o = idx;
          busy_o              = 1'b1;
        end
        S_PROC: begin
          ram.L_f_RAM_WaDDR_o   = idx;
          ram.L_f_RAM_Wr_en_o   = 1'b1;
          ram.L_f_RAM_WR_DATA_o = y;
          busy_o                = 1'b1;
        end
        S_DONE: begin
          busy_o = 1'b1;
          done_o = 1'b1;
        end
        default: begin
          busy_o = 1'b0;
        end
      endcase
    end
  end

`ifdef I2S_FBLK_PEAK_EN
  logic [15:0] peak_acc;
  logic [15:0] y_abs;

  // The magnitude of -32768 does not fit in 15 bits, so it is clipped to 32767.
  always_comb begin
    if (y == 16'h8000) begin
      y_abs = 16'h7FFF;
    end else if (y[15]) begin
      y_abs = 16'h0000 - y;
    end else begin
      y_abs = y;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      peak_acc <= 16'h0000;
      peak_o   <= 16'h0000;
    end else begin
      if (start_blk) begin
        peak_acc <= 16'h0000;
      end else if ((state == S_PROC) && (y_abs > peak_acc)) begin
        peak_acc <= y_abs;
      end
      if (state == S_DONE) begin
        peak_o <= peak_acc;
      end
    end
  end
`else
  assign peak_o = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_rx_fblk_dcfilt.sv
// Directed bench for i2s_rx_fblk_dcfilt: RAM model, block-level scoreboard and
// hand-computed spot checks on latency, filter output, overrun and reset.
module tb_i2s_rx_fblk_dcfilt;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_start = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  shift = 4'd0;
  logic        busy, done, overrun;
  logic [15:0] peak;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  i2s_rx_fblk_dcfilt_if #(.ADDR_W(10)) ram_bus ();

  i2s_rx_fblk_dcfilt #(.ADDR_W(10)) dut (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst),
    .f_start_i (f_start),
    .enable_i  (enable),
    .shift_i   (shift),
    .ram       (ram_bus),
    .busy_o    (busy),
    .done_o    (done),
    .overrun_o (overrun),
    .peak_o    (peak),
    .state_dbg (state_dbg)
  );

  logic        wr_en;
  logic [9:0]  waddr, raddr;
  logic [15:0] wr_data;
  assign wr_en   = ram_bus.L_f_RAM_Wr_en_o;
  assign waddr   = ram_bus.L_f_RAM_WaDDR_o;
  assign raddr   = ram_bus.L_f_RAM_RaDDR_o;
  assign wr_data = ram_bus.L_f_RAM_WR_DATA_o;

  // Rx bank model with one cycle of read latency.
  logic [15:0] mem [1024];
  always @(posedge clk) ram_bus.L_f_RAM_RD_DATA_i <= mem[raddr];

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  int          m_dc = 0;
  int          exp_peak = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] wr_log [1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference filter over the whole bank with a fixed k.
  task automatic plan_block(input int k);
    int x, y, d, a;
    exp_q.delete();
    exp_peak = 0;
    for (int n = 0; n < 1024; n++) begin
      x = int'(mem[n]);
      if (x > 32767) x = x - 65536;
      if (k == 0) begin
        y = x;
      end else begin
        y = x - (m_dc >>> 8);
        d = x * 256 - m_dc;
        m_dc = m_dc + (d >>> k);
      end
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      a = (y < 0) ? -y : y;
      if (a > 32767) a = 32767;
      if (a > exp_peak) exp_peak = a;
      exp_q.push_back(y[15:0]);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (wr_en) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_data", wr_data, e);
      end
      check("wr_addr", waddr, wr_cnt % 1024);
      wr_log[wr_cnt % 1024] = wr_data;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wr_data", wr_data, 0);
    #1 rst = 1'b0;
    m_dc = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_overrun", overrun, 0);
    check("rst_peak", peak, 0);
    check("rst_state", state_dbg, 0);
  endtask

  // Pulses f_start; lat is the cycle number (cycle 1 follows the sampling edge) of done.
  task automatic run_block(input int pulse_at, input int drop_en_at, output int lat);
    wr_cnt = 0;
    @(negedge clk) f_start = 1'b1;
    @(negedge clk) f_start = 1'b0;
    lat = 1;
    while (!done && lat < 2200) begin
      f_start = (lat == pulse_at);
      if (lat == drop_en_at) enable = 1'b0;
      @(negedge clk);
      lat++;
    end
    f_start = 1'b0;
    check("done_seen", done, 1);
  endtask

  task automatic settle_and_check_block(input int lat, input int done_before);
    repeat (4) @(negedge clk);
    check("latency", lat, 2049);
    check("wr_count", wr_cnt, 1024);
    check("done_pulses", done_cnt - done_before, 1);
    check("idle_after", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
`ifdef I2S_FBLK_PEAK_EN
    check("peak", peak, exp_peak);
`else
    check("peak_off", peak, 0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int d0;

    do_reset();

    // Bypass: ramp passes straight through.
    for (int n = 0; n < 1024; n++) mem[n] = 16'(n);
    shift = 4'd0;
    plan_block(0);
    d0 = done_cnt;
    run_block(0, 0, lat);
    settle_and_check_block(lat, d0);
    check("ramp_y5", wr_log[5], 16'd5);
    check("ramp_y1023", wr_log[1023], 16'd1023);
`ifdef I2S_FBLK_PEAK_EN
    check("ramp_peak", peak, 16'd1023);
`endif
    check("no_overrun", overrun, 0);

    // k=4 step response from dc=0.
    for (int n = 0; n < 1024; n++) mem[n] = 16'h1000;
    shift = 4'd4;
    plan_block(4);
    d0 = done_cnt;
    run_block(0, 0, lat);
    settle_and_check_block(lat, d0);
    check("k4_y0", wr_log[0], 16'h1000);
    check("k4_y1", wr_log[1], 16'h0F00);
    check("k4_y2", wr_log[2], 16'h0E10);
    check("k4_y_settled", wr_log[1023], 16'h0001);

    // k=1 drives dc to the positive rail, then a full-scale negative sample
    // saturates; enable drops mid-block without aborting it.
    for (int n = 0; n < 1023; n++) mem[n] = 16'h7FFF;
    mem[1023] = 16'h8000;
    shift = 4'd1;
    plan_block(1);
    d0 = done_cnt;
    run_block(0, 50, lat);
    settle_and_check_block(lat, d0);
    check("sat_neg", wr_log[1023], 16'h8000);
    enable = 1'b1;

    // Second start at cycle 100: overrun, no restart.
    for (int n = 0; n < 1024; n++) mem[n] = 16'(n * 3);
    shift = 4'd0;
    plan_block(0);
    d0 = done_cnt;
    run_block(100, 0, lat);
    settle_and_check_block(lat, d0);
    check("overrun_mid", overrun, 1);
    repeat (10) @(negedge clk);
    check("overrun_sticky", overrun, 1);
    check("no_restart", busy, 0);

    // Start coinciding with DONE.
    do_reset();
    shift = 4'd2;
    plan_block(2);
    d0 = done_cnt;
    run_block(0, 0, lat);
    f_start = 1'b1;
    @(negedge clk) f_start = 1'b0;
    repeat (10) @(negedge clk);
    check("done_start_overrun", overrun, 1);
    check("done_start_idle", busy, 0);
    check("done_start_writes", wr_cnt, 1024);
    check("done_start_pulses", done_cnt - d0, 1);

    // Reset at cycle 500 aborts the block.
    do_reset();
    for (int n = 0; n < 1024; n++) mem[n] = 16'h1000;
    shift = 4'd4;
    plan_block(4);
    d0 = done_cnt;
    wr_cnt = 0;
    @(negedge clk) f_start = 1'b1;
    @(negedge clk) f_start = 1'b0;
    lat = 1;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    m_dc = 0;
    repeat (20) @(negedge clk);
    check("abort_writes", wr_cnt, 250);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_state", state_dbg, 0);

    // Clean block after abort shows dc was cleared.
    plan_block(4);
    d0 = done_cnt;
    run_block(0, 0, lat);
    settle_and_check_block(lat, d0);
    check("post_abort_y0", wr_log[0], 16'h1000);
    check("post_abort_y1", wr_log[1], 16'h0F00);

    // Start ignored while disabled.
    enable = 1'b0;
    wr_cnt = 0;
    d0 = done_cnt;
    @(negedge clk) f_start = 1'b1;
    @(negedge clk) f_start = 1'b0;
    repeat (20) @(negedge clk);
    check("dis_busy", busy, 0);
    check("dis_state", state_dbg, 0);
    check("dis_writes", wr_cnt, 0);
    check("dis_done", done_cnt - d0, 0);
    check("dis_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
